// File: rtl/nrzi_pkg.sv
// Shared definitions for the NRZI receive path: FSM state encoding,
// the default frame-sync pattern and a counter-width helper.
package nrzi_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'h7E;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    if (n > 1) return $clog2(n);
    else       return 1;
  endfunction

endpackage

// File: rtl/nrzi_bit_decoder.sv
// Recovers the transmitted T bit from the NRZI line: a 1 is a line toggle,
// a 0 is a held level. Only advances on bit_en strobes.
module nrzi_bit_decoder
  import nrzi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_en,
  input  logic line_in,
  output logic t_bit,
  output logic t_valid
);

  logic r_prev_line;

  // Remember the line level seen at the previous bit strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_line <= 1'b0;
    end else if (bit_en) begin
      r_prev_line <= line_in;
    end
  end

  assign t_bit   = line_in ^ r_prev_line;
  assign t_valid = bit_en;

endmodule

// File: rtl/nrzi_rx.sv
// NRZI frame receiver: hunts for the sync pattern in the decoded bit
// stream, then deserialises FRAME_BYTES words (MSB first) into a
// single-entry valid/ready output register.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_HUNT | sliding the shift reg over decoded bits, looking for sync
//   ST_DATA | sync found; collecting payload words until the frame ends
module nrzi_rx
  import nrzi_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] SYNC_PATTERN = DATA_W'(SYNC_DEFAULT),
  parameter int                FRAME_BYTES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              line_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              sync_locked,
  output logic              overflow
);

  localparam int BIT_CNT_W  = cnt_w(DATA_W);
  localparam int BYTE_CNT_W = cnt_w(FRAME_BYTES);

  localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0]  BIT_ONE   = BIT_CNT_W'(1);
  localparam logic [BYTE_CNT_W-1:0] BYTE_LAST = BYTE_CNT_W'(FRAME_BYTES - 1);
  localparam logic [BYTE_CNT_W-1:0] BYTE_ONE  = BYTE_CNT_W'(1);

  logic w_t_bit;
  logic w_t_valid;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_W-1:0]     r_shift;
  logic [DATA_W-1:0]     w_shift_next;
  logic [DATA_W-1:0]     w_shifted;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [BIT_CNT_W-1:0]  w_bit_cnt_next;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [BYTE_CNT_W-1:0] w_byte_cnt_next;
  logic                  w_word_done;
  logic                  w_word_last;

  logic [DATA_W-1:0]     r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_overflow;
  logic                  w_load;
  logic                  w_pop;

  nrzi_bit_decoder u_dec (
    .clk     (clk),
    .rst     (rst),
    .bit_en  (bit_en),
    .line_in (line_in),
    .t_bit   (w_t_bit),
    .t_valid (w_t_valid)
  );

  assign w_shifted = {r_shift[DATA_W-2:0], w_t_bit};

  // Next-state, shift and counter logic; everything holds without a strobe.
  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_byte_cnt_next = r_byte_cnt;
    w_word_done     = 1'b0;
    w_word_last     = 1'b0;
    if (w_t_valid) begin
      w_shift_next = w_shifted;
      case (r_state)
        ST_HUNT: begin
          if (w_shifted == SYNC_PATTERN) begin
            w_state_next    = ST_DATA;
            w_bit_cnt_next  = '0;
            w_byte_cnt_next = '0;
          end
        end
        ST_DATA: begin
          if (r_bit_cnt == BIT_LAST) begin
            w_word_done    = 1'b1;
            w_bit_cnt_next = '0;
            if (r_byte_cnt == BYTE_LAST) begin
              // Clearing the shift reg stops the tail of this frame
              // from combining with fresh bits into a false sync.
              w_word_last     = 1'b1;
              w_byte_cnt_next = '0;
              w_state_next    = ST_HUNT;
              w_shift_next    = '0;
            end else begin
              w_byte_cnt_next = r_byte_cnt + BYTE_ONE;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + BIT_ONE;
          end
        end
        default: begin
          w_state_next = ST_HUNT;
        end
      endcase
    end
  end

  // FSM state, shift register and frame-position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_byte_cnt <= w_byte_cnt_next;
    end
  end

  // A finished word may enter the output register when it is empty or
  // being drained in the same cycle; otherwise it is lost.
  assign w_load = w_word_done & (~r_out_valid | out_ready);
  assign w_pop  = r_out_valid & out_ready;

  // Single-entry output register with sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_data  <= w_shifted;
        r_out_valid <= 1'b1;
        r_out_last  <= w_word_last;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if (w_word_done && !w_load) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign overflow    = r_overflow;
  assign sync_locked = (r_state == ST_DATA);

endmodule

// File: tb/tb_nrzi_rx.sv
// Self-checking bench for nrzi_rx: directed scenarios plus randomized
// frames, compared against a bit-level behavioural model of the link.
module tb_nrzi_rx;

  localparam int          DW   = 8;
  localparam int          FB   = 4;
  localparam logic [7:0]  SYNC = 8'h7E;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       line_in;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       sync_locked;
  logic       overflow;

  nrzi_rx #(.DATA_W(DW), .SYNC_PATTERN(SYNC), .FRAME_BYTES(FB)) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_en      (bit_en),
    .line_in     (line_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .sync_locked (sync_locked),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       tx_line;
  logic [7:0] words_a [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
  logic [7:0] words_b [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
  logic [7:0] words_c [4] = '{8'h7E, 8'h11, 8'h7E, 8'h22};

  // Behavioural model: link-level bookkeeping with plain integers.
  logic       m_prev;
  int         m_win;
  bit         m_locked;
  int         m_nbits;
  int         m_nwords;
  int         m_word;
  logic       m_valid;
  logic       m_last;
  logic       m_ovf;
  logic [7:0] m_data;

  task automatic model_reset();
    m_prev = 0; m_win = 0; m_locked = 0; m_nbits = 0; m_nwords = 0; m_word = 0;
    m_valid = 0; m_last = 0; m_ovf = 0; m_data = 8'h00;
  endtask

  task automatic model_edge(input logic en, input logic ln, input logic rdy);
    bit done = 0;
    bit lst  = 0;
    int w    = 0;
    int t;
    if (en) begin
      t = (ln != m_prev) ? 1 : 0;
      m_prev = ln;
      if (!m_locked) begin
        m_win = (m_win * 2 + t) % 256;
        if (m_win == int'(SYNC)) begin
          m_locked = 1; m_nbits = 0; m_nwords = 0; m_word = 0;
        end
      end else begin
        m_word = (m_word * 2 + t) % 256;
        m_nbits++;
        if (m_nbits == DW) begin
          done = 1; w = m_word; m_nbits = 0; m_nwords++;
          if (m_nwords == FB) begin
            lst = 1; m_locked = 0; m_win = 0;
          end
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data = 8'(w); m_valid = 1; m_last = lst;
      end else begin
        m_ovf = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0; m_last = 0;
    end
  endtask

  task automatic step(input logic en, input logic ln, input logic rdy);
    bit_en = en; line_in = ln; out_ready = rdy;
    model_edge(en, ln, rdy);
    @(posedge clk); #1;
  endtask

  task automatic send_t(input logic t, input logic rdy);
    tx_line = tx_line ^ t;
    step(1'b1, tx_line, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b0, tx_line, rdy);
  endtask

  task automatic send_byte(input logic [7:0] w, input logic rdy, input int gap);
    for (int i = 7; i >= 0; i--) begin
      send_t(w[i], rdy);
      if (i > 0) idle(gap, rdy);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1; bit_en = 0; out_ready = 0; line_in = 0;
    repeat (n) @(posedge clk);
    #1 rst = 0;
    model_reset();
    tx_line = 0;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_checks++;
    if ({out_valid, out_last, sync_locked, overflow, out_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b l=%b s=%b o=%b d=%h, need all zero",
               out_valid, out_last, sync_locked, overflow, out_data);
    end
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      idle(3, 1'b0);
      n_checks++;
      if ({out_valid, sync_locked, overflow} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_line bit %0d: got v=%b s=%b o=%b, need 000",
                 i, out_valid, sync_locked, overflow);
      end
    end
  endtask

  task automatic test_frame();
    do_reset(2);
    send_byte(SYNC, 1'b1, 2);
    n_checks++;
    if (sync_locked !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_sync: got s=%b v=%b, need s=1 v=0", sync_locked, out_valid);
    end
    idle(2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      send_byte(words_a[k], 1'b1, 2);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== words_a[k] || out_last !== (k == 3) ||
          sync_locked !== (k != 3)) begin
        n_fail++;
        $display("FAIL frame_word %0d: got v=%b d=%h l=%b s=%b, need v=1 d=%h l=%b s=%b",
                 k, out_valid, out_data, out_last, sync_locked, words_a[k], k == 3, k != 3);
      end
      idle(2, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0) begin
        n_fail++;
        $display("FAIL frame_drain %0d: got v=%b l=%b, need 0 0", k, out_valid, out_last);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(2);
    send_byte(SYNC, 1'b0, 1);
    idle(2, 1'b0);
    send_byte(words_a[0], 1'b0, 1);
    idle(2, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_first: got v=%b d=%h o=%b, need v=1 d=a5 o=0", out_valid, out_data, overflow);
    end
    send_byte(words_a[1], 1'b0, 1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_last !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drop: got v=%b d=%h l=%b o=%b, need v=1 d=a5 l=0 o=1",
               out_valid, out_data, out_last, overflow);
    end
    idle(2, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b o=%b, need v=0 o=1", out_valid, overflow);
    end
    send_byte(words_a[2], 1'b1, 1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_third: got v=%b d=%h l=%b, need v=1 d=ff l=0", out_valid, out_data, out_last);
    end
    idle(2, 1'b1);
    send_byte(words_a[3], 1'b1, 1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h00 || out_last !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_last: got v=%b d=%h l=%b o=%b, need v=1 d=00 l=1 o=1",
               out_valid, out_data, out_last, overflow);
    end
    idle(2, 1'b1);
  endtask

  task automatic test_accept_refill();
    do_reset(2);
    send_byte(SYNC, 1'b0, 1);
    idle(2, 1'b0);
    send_byte(words_a[0], 1'b0, 1);
    idle(2, 1'b0);
    for (int i = 7; i >= 1; i--) begin
      send_t(words_a[1][i], 1'b0);
      idle(2, 1'b0);
    end
    send_t(words_a[1][0], 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL refill: got v=%b d=%h o=%b, need v=1 d=3c o=0", out_valid, out_data, overflow);
    end
    idle(2, 1'b1);
    send_byte(words_a[2], 1'b1, 1);
    idle(1, 1'b1);
    send_byte(words_a[3], 1'b1, 1);
    n_checks++;
    if (out_data !== 8'h00 || out_last !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL refill_tail: got d=%h l=%b o=%b, need d=00 l=1 o=0", out_data, out_last, overflow);
    end
    idle(2, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    send_byte(SYNC, 1'b0, 1);
    send_byte(words_a[0], 1'b0, 1);
    send_byte(words_a[1], 1'b0, 1);
    for (int i = 7; i >= 5; i--) send_t(words_a[2][i], 1'b0);
    rst = 1; bit_en = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    tx_line = 0;
    n_checks++;
    if ({out_valid, out_last, sync_locked, overflow, out_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b l=%b s=%b o=%b d=%h, need all zero",
               out_valid, out_last, sync_locked, overflow, out_data);
    end
    send_byte(SYNC, 1'b1, 1);
    for (int k = 0; k < 4; k++) begin
      send_byte(words_b[k], 1'b1, 1);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== words_b[k] || out_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL mid_refr %0d: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                 k, out_valid, out_data, out_last, words_b[k], k == 3);
      end
      idle(1, 1'b1);
    end
  endtask

  task automatic test_false_sync();
    do_reset(2);
    send_byte(SYNC, 1'b1, 1);
    for (int k = 0; k < 4; k++) begin
      send_byte(words_c[k], 1'b1, 1);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== words_c[k] || out_last !== (k == 3) ||
          sync_locked !== (k != 3)) begin
        n_fail++;
        $display("FAIL false_sync %0d: got v=%b d=%h l=%b s=%b, need v=1 d=%h l=%b s=%b",
                 k, out_valid, out_data, out_last, sync_locked, words_c[k], k == 3, k != 3);
      end
      idle(1, 1'b1);
    end
    send_byte(8'h55, 1'b1, 1);
    idle(1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || sync_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL post_frame_hunt: got v=%b s=%b, need 0 0", out_valid, sync_locked);
    end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    do_reset(2);
    for (int f = 0; f < 2; f++) begin
      for (int i = 7; i >= 0; i--) send_t(SYNC[i], 1'b1);
      for (int k = 0; k < 4; k++) begin
        for (int i = 7; i >= 0; i--) begin
          send_t(words_b[k][i], 1'b1);
          if (out_valid === 1'b1) seen++;
          n_checks++;
          if ({out_valid, out_last, sync_locked, overflow, out_data} !==
              {m_valid, m_last, m_locked, m_ovf, m_data}) begin
            n_fail++;
            $display("FAIL b2b f%0d w%0d: got v=%b l=%b s=%b o=%b d=%h, need v=%b l=%b s=%b o=%b d=%h",
                     f, k, out_valid, out_last, sync_locked, overflow, out_data,
                     m_valid, m_last, m_locked, m_ovf, m_data);
          end
        end
      end
    end
    n_checks++;
    if (seen != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d words, need 8", seen);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       rdy;
    do_reset(2);
    for (int f = 0; f < 8; f++) begin
      int nnoise = $urandom_range(0, 12);
      for (int j = 0; j < nnoise + 40; j++) begin
        if (j < nnoise)            b = 8'($urandom_range(0, 1));
        else if (j < nnoise + 8)   b = {7'b0, SYNC[7 - (j - nnoise)]};
        else                       b = 8'($urandom_range(0, 1));
        rdy = 1'($urandom_range(0, 3) != 0);
        send_t(b[0], rdy);
        n_checks++;
        if ({out_valid, out_last, sync_locked, overflow, out_data} !==
            {m_valid, m_last, m_locked, m_ovf, m_data}) begin
          n_fail++;
          $display("FAIL rand f%0d b%0d: got v=%b l=%b s=%b o=%b d=%h, need v=%b l=%b s=%b o=%b d=%h",
                   f, j, out_valid, out_last, sync_locked, overflow, out_data,
                   m_valid, m_last, m_locked, m_ovf, m_data);
        end
        idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_accept_refill();
    test_reset_mid();
    test_false_sync();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nrzi_rx.md
Name: nrzi_rx

Overview:
- Receive end of the team's toggle-encoded (NRZI) serial link. The transmitter drives the line from a T flip-flop: bit 1 toggles the line, bit 0 holds it.
- This block recovers each T bit as line XOR previous line, hunts for a sync byte, then deserialises a fixed-length frame.
- Bytes are delivered over a valid/ready stream to the downstream consumer.

Parameters:
- DATA_W, 8, bits per deserialised word and width of the sync pattern.
- SYNC_PATTERN, 8'h7E, decoded-bit pattern that marks start of frame.
- FRAME_BYTES, 4, data words per frame after sync (>=1).

Ports:
- clk, input, 1, single system clock, rising edge.
- rst, input, 1, synchronous, active-high reset.
- bit_en, input, 1, one-cycle strobe: sample line_in this cycle.
- line_in, input, 1, NRZI line level, already synchronised to clk.
- out_data, output, DATA_W, recovered word, MSB = first bit received.
- out_valid, output, 1, out_data/out_last hold a word.
- out_ready, input, 1, consumer accepts the word when high with out_valid.
- out_last, output, 1, qualifies the final word of a frame.
- sync_locked, output, 1, high while in DATA state.
- overflow, output, 1, sticky: a completed word was dropped.

Behaviour:
- Reset (rst high at a clk edge): prev_line=0, shift reg=0, state=HUNT, bit_cnt=0, byte_cnt=0, out_data=0, out_valid=0, out_last=0, overflow=0, sync_locked=0.
- Reset mid-frame: partial word and frame are discarded.
- Decode, on bit_en only: t = line_in ^ prev_line; prev_line <= line_in. When bit_en=0, decode and FSM state are frozen.
- HUNT:
  - Shift t into the LSB of a DATA_W shift reg.
  - If the post-shift value equals SYNC_PATTERN, go to DATA with bit_cnt=0 and byte_cnt=0.
  - The sync byte is never output.
- DATA:
  - Shift t in and increment bit_cnt.
  - When bit_en arrives with bit_cnt==DATA_W-1, the word is complete: bit_cnt=0, byte_cnt+1.
  - If byte_cnt was FRAME_BYTES-1, mark the word last, go to HUNT and clear the shift reg (a new sync needs a full DATA_W fresh bits).
- Output register, single entry:
  - A completed word loads out_data, sets out_valid=1 and out_last=(last word) on the next edge.
  - Latency: 1 clk from the bit_en carrying the final bit.
  - It loads if out_valid=0, or out_ready=1 in the same cycle (accept and refill simultaneously; no overflow).
  - Otherwise the word is dropped, overflow <= 1, and out_data/out_valid/out_last stay unchanged.
  - The frame position still advances on a drop.
- Handshake:
  - out_valid stays high and out_data/out_last stay stable until out_ready=1.
  - out_ready=1 with out_valid=1 and no new word clears out_valid and out_last.
  - out_ready is ignored while out_valid=0.
- overflow clears only on rst.
- sync_locked = (state==DATA), registered.
- A sync pattern appearing inside DATA is treated as payload.
- Counters: bit_cnt is clog2(DATA_W) bits; byte_cnt is clog2(FRAME_BYTES) bits, minimum 1.

Decomposition:
- Package nrzi_pkg: state encoding (HUNT=0, DATA=1) and the default SYNC_PATTERN constant.
- Sub-module nrzi_bit_decoder: prev_line register and XOR, outputs t_bit and t_valid (=bit_en).
- Parent holds the FSM, shift reg, counters and output register.

Test Plan:
- Reset/idle: rst for 2 clk, line_in held 0 with bit_en every 4th clk for 64 bits -> out_valid=0, sync_locked=0, overflow=0 throughout.
- Sync + frame: from line=0, send bits 0,1,1,1,1,1,1,0 (line 0,1,0,1,0,1,0,0), then words A5,3C,FF,00, out_ready=1 -> four words A5,3C,FF,00 in order; out_last only on 00; each word valid 1 clk after its 8th bit; sync_locked falls after the last word.
- Backpressure: same frame with out_ready=0 until after the second word completes -> out_data=A5 held, 3C dropped, overflow=1 and stays 1; after out_ready=1, FF and 00 are delivered.
- Simultaneous accept/refill: out_ready pulsed high exactly on the cycle the next word completes -> new word loaded, overflow=0.
- Reset mid-frame: assert rst after 2 words plus 3 bits -> outputs zero next clk; a new sync followed by 4 words decodes correctly.
- False sync: payload word 7E inside a frame -> delivered as data; frame length is still 4.
